tnn_stream_neuron: RTL

// - Parametrised streaming ternary-weight neuron. Successor to the fixed 6x3-bit combinational

---
 rtl/tnn_stream_neuron.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tnn_stream_neuron.sv
// Streaming ternary-weight neuron: one unsigned feature per beat, signed weighted sum vs threshold.
// Latency: result registered the cycle after the final beat; N+1 cycles per frame at m_ready=1.
// Backpressure: s_ready drops while a result is pending; the result holds until m_ready.
module tnn_stream_neuron #(
  parameter  int NUM_FEATURES = 6,
  parameter  int FEAT_W       = 3,
  localparam int ACC_W        = FEAT_W + $clog2(NUM_FEATURES) + 1,
  localparam int IDX_W        = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [FEAT_W-1:0]       s_feat,
  input  logic                    s_last,
  input  logic                    cfg_w_we,
  input  logic [IDX_W-1:0]        cfg_w_idx,
  input  logic [1:0]              cfg_w,
  input  logic                    cfg_t_we,
  input  logic signed [ACC_W-1:0] cfg_t,
  output logic                    busy,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_class,
  output logic signed [ACC_W-1:0] m_score,
  output logic                    m_err
);

  typedef enum logic {RUN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic [1:0]              w_q [NUM_FEATURES];
  logic [1:0]              w_d [NUM_FEATURES];
  logic                    m_valid_q, m_valid_d;
  logic                    m_class_q, m_class_d;
  logic signed [ACC_W-1:0] m_score_q, m_score_d;
  logic                    m_err_q, m_err_d;

  logic signed [ACC_W-1:0] feat_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic                    idx_last;
  logic                    cfg_open;
  logic                    cfg_idx_ok;

  assign s_ready    = (state_q == RUN);
  assign busy       = (idx_q != '0) || (state_q == OUT);
  assign m_valid    = m_valid_q;
  assign m_class    = m_class_q;
  assign m_score    = m_score_q;
  assign m_err      = m_err_q;

  assign idx_last   = (idx_q == IDX_W'(NUM_FEATURES - 1));
  assign cfg_open   = !busy;
  assign cfg_idx_ok = ({1'b0, cfg_w_idx} < (IDX_W + 1)'(NUM_FEATURES));
  assign feat_ext   = {{(ACC_W - FEAT_W){1'b0}}, s_feat};
  assign sum        = acc_q + term;

  // Code 10 is reserved and contributes nothing, same as 00.
  always_comb begin
    term = '0;
    case (w_q[idx_q])
      2'b01:   term = feat_ext;
      2'b11:   term = -feat_ext;
      default: term = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    w_d       = w_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    m_score_d = m_score_q;
    m_err_d   = m_err_q;

    // Config lands only between frames; a first beat in the same cycle still sees the old values.
    if (cfg_open && cfg_t_we) thr_d = cfg_t;
    if (cfg_open && cfg_w_we && cfg_idx_ok) w_d[cfg_w_idx] = cfg_w;

    case (state_q)
      RUN: begin
        if (s_valid) begin
          if (s_last || idx_last) begin
            m_score_d = sum;
            m_class_d = (sum >= thr_q);
            m_err_d   = (s_last != idx_last);
            m_valid_d = 1'b1;
            state_d   = OUT;
            acc_d     = '0;
            idx_d     = '0;
          end else begin
            acc_d = sum;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      idx_q     <= '0;
      acc_q     <= '0;
      thr_q     <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= 1'b0;
      m_score_q <= '0;
      m_err_q   <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) w_q[i] <= 2'b00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      thr_q     <= thr_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      m_score_q <= m_score_d;
      m_err_q   <= m_err_d;
      for (int i = 0; i < NUM_FEATURES; i++) w_q[i] <= w_d[i];
    end
  end

endmodule
